// File: rtl/stream_pkg.sv
// Shared lane-width helpers and the lane-count type for the parallel-lane stream fabric.
package stream_pkg;

  function automatic int lane_idx_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

  function automatic int lane_cnt_w(input int p);
    return $clog2(p + 1);
  endfunction

  localparam int DEFAULT_LANES = 4;

  typedef logic [lane_cnt_w(DEFAULT_LANES)-1:0] lane_cnt_t;

endpackage

// File: rtl/axi_stream_out_reg.sv
// Registered multi-lane output slice: holds data/last/count stable while valid && !ready.
module axi_stream_out_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data [LANES-1:0],
  input  logic                  load_last,
  input  logic [CNT_W-1:0]      load_count,
  input  logic                  m_ready,
  output logic                  out_free,
  output logic [DATA_WIDTH-1:0] m_data [LANES-1:0],
  output logic                  m_valid,
  output logic                  m_last,
  output logic [CNT_W-1:0]      m_count
);

  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q [LANES-1:0];
  logic [DATA_WIDTH-1:0] data_d [LANES-1:0];

  assign out_free = !valid_q || m_ready;

  // A load is only issued when out_free, so it may overwrite a beat leaving this cycle.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    count_d = count_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      last_d  = load_last;
      count_d = load_count;
      data_d  = load_data;
    end else if (m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      count_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign m_valid = valid_q;
  assign m_last  = last_q;
  assign m_count = count_q;
  assign m_data  = data_q;

endmodule

// File: rtl/axi_stream_lane_packer.sv
// Packs PARALLELISM consecutive scalar AXI-Stream elements into one wide beat;
// a packet's tail is flushed zero-padded with its lane count.
module axi_stream_lane_packer
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PARALLELISM = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [DATA_WIDTH-1:0]                 s_data,
  input  logic                                  s_valid,
  input  logic                                  s_last,
  output logic                                  s_ready,
  output logic [DATA_WIDTH-1:0]                 m_data [PARALLELISM-1:0],
  output logic                                  m_valid,
  output logic                                  m_last,
  input  logic                                  m_ready,
  output logic [lane_cnt_w(PARALLELISM)-1:0]    m_count
);

  localparam int IDX_W = lane_idx_w(PARALLELISM);
  localparam int CNT_W = lane_cnt_w(PARALLELISM);

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] acc_q [PARALLELISM-1:0];
  logic [DATA_WIDTH-1:0] acc_d [PARALLELISM-1:0];
  logic [DATA_WIDTH-1:0] beat  [PARALLELISM-1:0];
  logic [CNT_W-1:0]      beat_count;
  logic                  last_lane, s_fire, complete, out_free;

  assign last_lane = (idx_q == IDX_W'(PARALLELISM - 1));
  // Only an element that would complete a beat needs room in the output register.
  assign s_ready   = out_free || (!last_lane && !s_last);
  assign s_fire    = s_valid && s_ready;
  assign complete  = s_fire && (last_lane || s_last);
  assign beat_count = CNT_W'(idx_q) + CNT_W'(1);

  // Lanes above idx are still zero in acc, which gives the zero padding for free.
  always_comb begin
    for (int i = 0; i < PARALLELISM; i++) begin
      beat[i] = (i == int'(idx_q)) ? s_data : acc_q[i];
    end
  end

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    if (s_fire) begin
      if (complete) begin
        acc_d = '{default: '0};
        idx_d = '0;
      end else begin
        acc_d[idx_q] = s_data;
        idx_d        = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      acc_q <= '{default: '0};
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

  axi_stream_out_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .LANES     (PARALLELISM),
    .CNT_W     (CNT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (complete),
    .load_data (beat),
    .load_last (s_last),
    .load_count(beat_count),
    .m_ready   (m_ready),
    .out_free  (out_free),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_count   (m_count)
  );

endmodule

// File: tb/tb_axi_stream_lane_packer.sv
// Directed bench for the lane packer (P=4) plus random scoreboard runs at P=1 and P=3.
module tb_axi_stream_lane_packer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, s_valid, s_last, s_ready, m_valid, m_last, m_ready;
  logic [31:0] s_data;
  logic [31:0] m_data [3:0];
  logic [2:0]  m_count;

  int n_chk  = 0;
  int n_pass = 0;
  bit srdy_all;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  axi_stream_lane_packer #(.DATA_WIDTH(32), .PARALLELISM(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .m_count(m_count)
  );

  logic [127:0] cap_d [$];
  logic [2:0]   cap_c [$];
  logic         cap_l [$];

  // Inputs change at the falling edge (or 1 unit after); sample the handshake after that.
  always @(negedge clk) begin
    #2;
    if (m_valid && m_ready) begin
      cap_d.push_back({m_data[3], m_data[2], m_data[1], m_data[0]});
      cap_c.push_back(m_count);
      cap_l.push_back(m_last);
    end
  end

  function automatic logic [127:0] pk(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic send(input logic [31:0] d, input logic l);
    int w = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = l;
    #1;
    while (!s_ready && w < 50) begin
      @(negedge clk); #1; w++;
    end
    srdy_all = srdy_all && (w == 0);
    if (w >= 50) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string tag);
    int w = 0;
    while (cap_d.size() < n && w < 40) begin
      @(negedge clk); w++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_nbeats"}, cap_d.size(), n);
  endtask

  task automatic check_beat(input string tag, input int i, input logic [127:0] d,
                            input int c, input logic l);
    if (i < cap_d.size()) begin
      chk({tag, "_data"}, cap_d[i], d);
      chk({tag, "_cnt"}, cap_c[i], c);
      chk({tag, "_last"}, cap_l[i], l);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int P  = (g == 0) ? 1 : 3;
    localparam int CW = $clog2(P + 1);
    logic          rrst_n, rs_valid, rs_last, rs_ready, rm_valid, rm_last, rm_ready;
    logic [31:0]   rs_data;
    logic [31:0]   rm_data [P-1:0];
    logic [CW-1:0] rm_count;
    bit            done = 1'b0;

    axi_stream_lane_packer #(.DATA_WIDTH(32), .PARALLELISM(P)) u_dut (
      .clk(clk), .rst_n(rrst_n), .s_data(rs_data), .s_valid(rs_valid), .s_last(rs_last),
      .s_ready(rs_ready), .m_data(rm_data), .m_valid(rm_valid), .m_last(rm_last),
      .m_ready(rm_ready), .m_count(rm_count)
    );

    initial begin
      logic [127:0] e_d [$];
      int           e_c [$];
      logic         e_l [$];
      logic [127:0] macc, cur, prev_d;
      int           mlane, k, cyc, prev_c;
      logic         prev_l;
      bit           pend, prev_hold;
      macc = '0; mlane = 0; k = 0; cyc = 0; pend = 0; prev_hold = 0;
      prev_d = '0; prev_c = 0; prev_l = 0;
      rrst_n = 1'b0; rs_valid = 1'b0; rs_last = 1'b0; rs_data = '0; rm_ready = 1'b0;
      repeat (3) @(negedge clk);
      rrst_n = 1'b1;
      while ((k < 1000 || e_d.size() != 0) && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        if (!pend && k < 1000 && ($urandom % 4) != 0) begin
          pend    = 1'b1;
          rs_data = (32'(g + 1) << 28) | 32'(k);
          rs_last = (k == 999) || (($urandom % 7) == 0);
        end
        rs_valid = pend;
        rm_ready = (($urandom % 3) != 0);
        #1;
        cur = '0;
        for (int i = 0; i < P; i++) cur[i*32 +: 32] = rm_data[i];
        if (prev_hold)
          chk($sformatf("rnd%0d_stable", P),
              (rm_valid && cur == prev_d && int'(rm_count) == prev_c && rm_last == prev_l), 1);
        if (rm_valid && rm_ready) begin
          if (e_d.size() == 0) chk($sformatf("rnd%0d_extra_beat", P), 1, 0);
          else begin
            chk($sformatf("rnd%0d_data", P), cur, e_d.pop_front());
            chk($sformatf("rnd%0d_cnt", P), rm_count, e_c.pop_front());
            chk($sformatf("rnd%0d_last", P), rm_last, e_l.pop_front());
          end
        end
        if (rs_valid && rs_ready) begin
          macc[mlane*32 +: 32] = rs_data;
          mlane++;
          if (rs_last || mlane == P) begin
            e_d.push_back(macc); e_c.push_back(mlane); e_l.push_back(rs_last);
            macc = '0; mlane = 0;
          end
          k++;
          pend = 1'b0;
        end
        prev_hold = rm_valid && !rm_ready;
        prev_d = cur; prev_c = int'(rm_count); prev_l = rm_last;
      end
      rs_valid = 1'b0;
      chk($sformatf("rnd%0d_accepted", P), k, 1000);
      chk($sformatf("rnd%0d_pending", P), e_d.size(), 0);
      done = 1'b1;
    end
  end

  initial begin
    int acc;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_count", m_count, 0);
    chk("rst_m_data", pk(m_data[0], m_data[1], m_data[2], m_data[3]), 0);
    chk("rst_s_ready", s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Two full beats, no backpressure
    cap_d.delete(); cap_c.delete(); cap_l.delete();
    srdy_all = 1'b1;
    for (int i = 1; i <= 8; i++) send(32'(i), i == 8);
    idle();
    wait_beats(2, "t1");
    chk("t1_s_ready", srdy_all, 1);
    check_beat("t1_b0", 0, pk(1, 2, 3, 4), 4, 0);
    check_beat("t1_b1", 1, pk(5, 6, 7, 8), 4, 1);

    // Partial tail beat
    cap_d.delete(); cap_c.delete(); cap_l.delete();
    for (int i = 0; i < 6; i++) send(32'hA0 + 32'(i), i == 5);
    idle();
    wait_beats(2, "t2");
    check_beat("t2_b0", 0, pk(32'hA0, 32'hA1, 32'hA2, 32'hA3), 4, 0);
    check_beat("t2_b1", 1, pk(32'hA4, 32'hA5, 0, 0), 2, 1);

    // Single-element packet, one-cycle latency
    send(32'hDEAD, 1'b1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    #1;
    chk("t4_valid", m_valid, 1);
    chk("t4_data", pk(m_data[0], m_data[1], m_data[2], m_data[3]), pk(32'hDEAD, 0, 0, 0));
    chk("t4_cnt", m_count, 1);
    chk("t4_last", m_last, 1);
    @(negedge clk); #1;
    chk("t4_drop", m_valid, 0);

    // Backpressure: output full plus three lanes in the accumulator
    repeat (2) @(negedge clk);
    cap_d.delete(); cap_c.delete(); cap_l.delete();
    m_ready = 1'b0; acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 32'h30 + 32'(acc); s_last = 1'b0;
      #1;
      if (s_ready) acc++;
    end
    chk("t3_accepts", acc, 7);
    @(negedge clk); #1;
    chk("t3_s_ready", s_ready, 0);
    chk("t3_hold", {m_valid, m_data[0], m_data[3]}, {1'b1, 32'h30, 32'h33});
    s_last = 1'b1; m_ready = 1'b1;
    idle();
    wait_beats(2, "t3");
    check_beat("t3_b0", 0, pk(32'h30, 32'h31, 32'h32, 32'h33), 4, 0);
    check_beat("t3_b1", 1, pk(32'h34, 32'h35, 32'h36, 32'h37), 4, 1);

    // Reset in the middle of a packet
    cap_d.delete(); cap_c.delete(); cap_l.delete();
    send(32'h50, 1'b0);
    send(32'h51, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", m_valid, 0);
    repeat (2) @(negedge clk);
    chk("t5_rst_hold", m_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h60 + 32'(i), i == 3);
    idle();
    wait_beats(1, "t5");
    check_beat("t5_b0", 0, pk(32'h60, 32'h61, 32'h62, 32'h63), 4, 1);

    wait (g_rnd[0].done && g_rnd[1].done);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
